if_fetch_unit: RTL

//   IF-stage fetch engine: consumer of the PC register's address output.

---
 rtl/if_fetch_unit_pkg.sv | 25 ++
 rtl/if_fetch_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_unit_pkg
//   Shared definitions for the IF-stage fetch engine.
//   - INST_W / BYTE_W : instruction width and memory-port byte width.
//   - if_state_e      : 2-bit fetch FSM encoding (IDLE / BUSY / HOLD).
//   - is_misaligned() : word-alignment test on the low PC bits, used only
//                       when FETCH_MISALIGN_TRAP_EN is defined.
// -----------------------------------------------------------------------------
package if_fetch_unit_pkg;

    localparam int INST_W = 32;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IF_IDLE = 2'b00,
        IF_BUSY = 2'b01,
        IF_HOLD = 2'b10
    } if_state_e;

    // A fetch address is word aligned when its two low bits are zero.
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return (low_bits != 2'b00);
    endfunction

endpackage

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
//   IF-stage fetch engine. Latches the PC, reads one instruction over a
//   byte-wide req/ack memory port (one byte per acknowledged transfer,
//   little-endian assembly), and presents it to the IF/ID latch. stallreq_if
//   stays high until the instruction is complete so PC and IF/ID wait for it.
//   A branch redirect (br) aborts any fetch in flight so the redirected PC is
//   fetched next.
//
// Parameters
//   ADDR_W          address width
//   BYTES_PER_INST  bytes per instruction (4 for RV32I)
//
// Ports
//   clk            in   clock, rising edge
//   rst            in   synchronous reset, active-high
//   pc             in   current PC from the PC register
//   br             in   branch redirect / flush from EX
//   id_stall       in   downstream stall; inst must be held while high
//   mem_req        out  byte read request
//   mem_addr       out  byte address of the current request
//   mem_ack        in   memory returned mem_rdata this cycle
//   mem_rdata      in   returned byte
//   inst           out  assembled instruction, little-endian
//   inst_valid     out  inst is complete and valid
//   inst_misalign  out  misaligned-fetch flag
//   stallreq_if    out  stall request to the stall controller (stall[0])
//
// Configuration
//   FETCH_MISALIGN_TRAP_EN : when defined, a PC with pc[1:0]!=0 skips the bus
//     entirely and is reported in HOLD with inst=0 and inst_misalign=1.
//     When undefined, inst_misalign is always 0 and unaligned PCs are fetched
//     byte by byte starting at the latched address.
// -----------------------------------------------------------------------------
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int BYTES_PER_INST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              br,
    input  logic              id_stall,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic [31:0]       inst,
    output logic              inst_valid,
    output logic              inst_misalign,
    output logic              stallreq_if
);

    localparam int CNT_W = (BYTES_PER_INST > 1) ? $clog2(BYTES_PER_INST) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTES_PER_INST - 1);

    if_state_e         state;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  cnt;
    logic [INST_W-1:0] inst_buf;
    logic [INST_W-1:0] buf_next;
    logic              misalign_q;
    logic              pc_misaligned;

    // Drop one byte into its little-endian lane of the assembly buffer.
    function automatic logic [INST_W-1:0] put_byte(
        input logic [INST_W-1:0] word,
        input logic [CNT_W-1:0]  lane,
        input logic [7:0]        data
    );
        logic [INST_W-1:0] r;
        int unsigned       sh;
        r  = word;
        sh = BYTE_W * int'(lane);
        r[sh +: BYTE_W] = data;
        return r;
    endfunction

`ifdef FETCH_MISALIGN_TRAP_EN
    assign pc_misaligned = is_misaligned(pc[1:0]);
`else
    assign pc_misaligned = 1'b0;
`endif

    // Buffer contents including the byte arriving this cycle; the last byte
    // goes straight into inst so the instruction is visible on HOLD entry.
    assign buf_next = put_byte(inst_buf, cnt, mem_rdata);

    // Address arithmetic wraps naturally at 2^ADDR_W.
    assign mem_addr      = addr_q + ADDR_W'(cnt);
    assign inst_misalign = misalign_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IF_IDLE;
            cnt         <= '0;
            addr_q      <= '0;
            inst_buf    <= '0;
            inst        <= '0;
            inst_valid  <= 1'b0;
            misalign_q  <= 1'b0;
            mem_req     <= 1'b0;
            stallreq_if <= 1'b1;
        end else if (br) begin
            // Redirect beats everything: any same-cycle ack is discarded and
            // the request is withdrawn on this edge.
            state       <= IF_IDLE;
            cnt         <= '0;
            inst_valid  <= 1'b0;
            misalign_q  <= 1'b0;
            mem_req     <= 1'b0;
            stallreq_if <= 1'b1;
        end else begin
            case (state)
                IF_IDLE: begin
                    addr_q   <= pc;
                    cnt      <= '0;
                    inst_buf <= '0;
                    if (pc_misaligned) begin
                        state       <= IF_HOLD;
                        inst        <= '0;
                        inst_valid  <= 1'b1;
                        misalign_q  <= 1'b1;
                        mem_req     <= 1'b0;
                        stallreq_if <= 1'b0;
                    end else begin
                        state       <= IF_BUSY;
                        mem_req     <= 1'b1;
                        stallreq_if <= 1'b1;
                    end
                end

                IF_BUSY: begin
                    if (mem_ack) begin
                        inst_buf <= buf_next;
                        cnt      <= cnt + 1'b1;
                        if (cnt == LAST_CNT) begin
                            state       <= IF_HOLD;
                            inst        <= buf_next[31:0];
                            inst_valid  <= 1'b1;
                            mem_req     <= 1'b0;
                            stallreq_if <= 1'b0;
                        end
                    end
                end

                IF_HOLD: begin
                    // PC advances on the same edge that releases HOLD.
                    if (!id_stall) begin
                        state       <= IF_IDLE;
                        inst_valid  <= 1'b0;
                        misalign_q  <= 1'b0;
                        stallreq_if <= 1'b1;
                    end
                end

                default: begin
                    state       <= IF_IDLE;
                    cnt         <= '0;
                    inst_valid  <= 1'b0;
                    misalign_q  <= 1'b0;
                    mem_req     <= 1'b0;
                    stallreq_if <= 1'b1;
                end
            endcase
        end
    end

endmodule
